// File: rtl/sym_cn_lut_loader_if.sv
// Load-command, entry-stream and RAM write-port signals of the symmetric CN LUT loader.
// The slave modport is the loader side; the master modport is the command/stream source and RAM sink.
interface sym_cn_lut_loader_if #(
  parameter int QUAN_SIZE       = 2,
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2
);
  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);

  logic                   load_start;
  logic                   load_frame;
  logic                   in_valid;
  logic [2*QUAN_SIZE-1:0] in_data;
  logic                   in_ready;
  logic [PAGE_W-1:0]      page_write_addr;
  logic                   write_addr_offset;
  logic [QUAN_SIZE-1:0]   lut_in_bank0;
  logic [QUAN_SIZE-1:0]   lut_in_bank1;
  logic                   we;
  logic                   busy;
  logic                   load_done;

  modport slave (
    input  load_start, load_frame, in_valid, in_data,
    output in_ready, page_write_addr, write_addr_offset,
           lut_in_bank0, lut_in_bank1, we, busy, load_done
  );

  modport master (
    output load_start, load_frame, in_valid, in_data,
    input  in_ready, page_write_addr, write_addr_offset,
           lut_in_bank0, lut_in_bank1, we, busy, load_done
  );
endinterface

// File: rtl/sym_cn_lut_loader.sv
// Fills one frame's half of the two-bank symmetric CN LUT RAM from a valid/ready stream of entry pairs.
// Every write-port output is registered, so the RAM sees each beat one cycle after it is accepted.
module sym_cn_lut_loader #(
  parameter int QUAN_SIZE       = 2,
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic                write_clk,
  input  logic                rst,
  sym_cn_lut_loader_if.slave  bus
);
  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);
  localparam logic [PAGE_W-1:0] LAST_PAGE = {PAGE_W{1'b1}};

  // state | meaning
  // IDLE  | waiting for load_start, stream not consumed
  // LOAD  | accepting beats, one RAM page per accept
  // DONE  | final write on the RAM port, load_done pulsed
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PAGE_W-1:0]    cnt_q, cnt_d;
  logic                 frame_q, frame_d;
  logic                 we_q, we_d;
  logic [PAGE_W-1:0]    addr_q, addr_d;
  logic                 off_q, off_d;
  logic [QUAN_SIZE-1:0] b0_q, b0_d;
  logic [QUAN_SIZE-1:0] b1_q, b1_d;
  logic                 accept;

  assign accept = (state_q == S_LOAD) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    off_d   = off_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d = S_LOAD;
          frame_d = bus.load_frame;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          off_d  = frame_q;
          b0_d   = bus.in_data[QUAN_SIZE-1:0];
          b1_d   = bus.in_data[2*QUAN_SIZE-1:QUAN_SIZE];
          // Counter wraps inside PAGE_W bits, never touching the frame offset.
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_PAGE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  assign bus.in_ready          = (state_q == S_LOAD);
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.load_done         = (state_q == S_DONE);
  assign bus.we                = we_q;
  assign bus.page_write_addr   = addr_q;
  assign bus.write_addr_offset = off_q;
  assign bus.lut_in_bank0      = b0_q;
  assign bus.lut_in_bank1      = b1_q;
endmodule

// File: tb/tb_sym_cn_lut_loader.sv
// Directed bench for sym_cn_lut_loader: reset, full loads, bubbles, ignored commands, mid-load reset, back-to-back.
module tb_sym_cn_lut_loader;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sym_cn_lut_loader_if #(.QUAN_SIZE(2), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2)) bus ();

  sym_cn_lut_loader #(.QUAN_SIZE(2), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2)) dut (
    .write_clk (clk),
    .rst       (rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat i carries {i, ~i}: bank 1 gets i, bank 0 gets ~i (2-bit masked).
  function automatic logic [3:0] mk(input int i);
    logic [1:0] v;
    v = i[1:0];
    return {v, ~v};
  endfunction

  function automatic logic [1:0] lo_of(input int i);
    logic [1:0] v;
    v = i[1:0];
    return ~v;
  endfunction

  function automatic logic [1:0] hi_of(input int i);
    logic [1:0] v;
    v = i[1:0];
    return v;
  endfunction

  task automatic start_load(input logic f);
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_frame = f;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
  endtask

  task automatic test_reset;
    start_load(1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1101;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.we, bus.busy, bus.load_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/we/busy/done=%b required 0000",
               {bus.in_ready, bus.we, bus.busy, bus.load_done});
    end
    n_checks++;
    if ({bus.page_write_addr, bus.write_addr_offset, bus.lut_in_bank0, bus.lut_in_bank1} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: addr/off/b0/b1=%h required 00",
               {bus.page_write_addr, bus.write_addr_offset, bus.lut_in_bank0, bus.lut_in_bank1});
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_load;
    start_load(1'b1);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_start: busy=%b ready=%b required 1 1", bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = mk(0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.we !== 1'b1 || bus.page_write_addr !== 3'(i) || bus.write_addr_offset !== 1'b1) begin
        n_fail++;
        $display("FAIL full_addr[%0d]: we=%b addr=%0d off=%b required 1 %0d 1",
                 i, bus.we, bus.page_write_addr, bus.write_addr_offset, i);
      end
      n_checks++;
      if (bus.lut_in_bank0 !== lo_of(i) || bus.lut_in_bank1 !== hi_of(i)) begin
        n_fail++;
        $display("FAIL full_data[%0d]: b0=%b b1=%b required %b %b",
                 i, bus.lut_in_bank0, bus.lut_in_bank1, lo_of(i), hi_of(i));
      end
      n_checks++;
      if (bus.load_done !== (i == 7) || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL full_done[%0d]: done=%b busy=%b required %b 1", i, bus.load_done, bus.busy, i == 7);
      end
      if (i < 7) bus.in_data = mk(i + 1);
      else       bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.we !== 1'b0 || bus.load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: busy=%b we=%b done=%b required 0 0 0", bus.busy, bus.we, bus.load_done);
    end
  endtask

  task automatic test_bubbles;
    int sent;
    logic v;
    sent = 0;
    start_load(1'b0);
    for (int k = 0; k < 40 && sent < 8; k++) begin
      v = (k % 3 == 0);
      bus.in_valid = v;
      bus.in_data  = v ? mk(sent + 2) : 4'b0110;
      @(posedge clk); #1;
      n_checks++;
      if (v) begin
        if (bus.we !== 1'b1 || bus.page_write_addr !== 3'(sent) || bus.write_addr_offset !== 1'b0 ||
            bus.lut_in_bank0 !== lo_of(sent + 2) || bus.lut_in_bank1 !== hi_of(sent + 2)) begin
          n_fail++;
          $display("FAIL bubble_write[%0d]: we=%b addr=%0d off=%b b0=%b b1=%b required 1 %0d 0 %b %b",
                   sent, bus.we, bus.page_write_addr, bus.write_addr_offset, bus.lut_in_bank0,
                   bus.lut_in_bank1, sent, lo_of(sent + 2), hi_of(sent + 2));
        end
        sent++;
      end else begin
        if (bus.we !== 1'b0 || bus.page_write_addr !== 3'(sent - 1) ||
            bus.lut_in_bank0 !== lo_of(sent + 1) || bus.lut_in_bank1 !== hi_of(sent + 1)) begin
          n_fail++;
          $display("FAIL bubble_hold[k=%0d]: we=%b addr=%0d b0=%b b1=%b required 0 %0d %b %b",
                   k, bus.we, bus.page_write_addr, bus.lut_in_bank0, bus.lut_in_bank1,
                   sent - 1, lo_of(sent + 1), hi_of(sent + 1));
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (sent !== 8 || bus.load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_count: writes=%0d done=%b required 8 1", sent, bus.load_done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_end: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_ignored_cmd;
    int writes;
    writes = 0;
    start_load(1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data    = mk(i);
      bus.load_start = (i == 3);
      bus.load_frame = 1'b0;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      if (bus.we === 1'b1) writes++;
      n_checks++;
      if (bus.we !== 1'b1 || bus.page_write_addr !== 3'(i) || bus.write_addr_offset !== 1'b1) begin
        n_fail++;
        $display("FAIL ignored_write[%0d]: we=%b addr=%0d off=%b required 1 %0d 1",
                 i, bus.we, bus.page_write_addr, bus.write_addr_offset, i);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (writes !== 8 || bus.busy !== 1'b0 || bus.we !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_end: writes=%0d busy=%b we=%b required 8 0 0", writes, bus.busy, bus.we);
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    stray = 0;
    start_load(1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = mk(i);
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus.we !== 1'b1 || bus.page_write_addr !== 3'd4) begin
      n_fail++;
      $display("FAIL midrst_pre: we=%b addr=%0d required 1 4", bus.we, bus.page_write_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.page_write_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_now: we=%b busy=%b addr=%0d required 0 0 0", bus.we, bus.busy, bus.page_write_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.we !== 1'b0 || bus.load_done !== 1'b0 || bus.in_ready !== 1'b0) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL midrst_after: stray we/done/ready cycles=%0d required 0", stray);
    end
    bus.in_valid = 1'b0;
    start_load(1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = mk(7 - i);
      @(posedge clk); #1;
      n_checks++;
      if (bus.we !== 1'b1 || bus.page_write_addr !== 3'(i) || bus.write_addr_offset !== 1'b0 ||
          bus.lut_in_bank0 !== lo_of(7 - i) || bus.lut_in_bank1 !== hi_of(7 - i)) begin
        n_fail++;
        $display("FAIL midrst_reload[%0d]: we=%b addr=%0d off=%b b0=%b b1=%b required 1 %0d 0 %b %b",
                 i, bus.we, bus.page_write_addr, bus.write_addr_offset, bus.lut_in_bank0,
                 bus.lut_in_bank1, i, lo_of(7 - i), hi_of(7 - i));
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    start_load(1'b1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = mk(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b required 1", bus.load_done);
    end
    bus.load_start = 1'b1;
    bus.load_frame = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ignored: busy=%b ready=%b required 0 0", bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b ready=%b required 1 1", bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = mk(i + 1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.we !== 1'b1 || bus.page_write_addr !== 3'(i) || bus.write_addr_offset !== 1'b0 ||
          bus.lut_in_bank0 !== lo_of(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: we=%b addr=%0d off=%b b0=%b required 1 %0d 0 %b",
                 i, bus.we, bus.page_write_addr, bus.write_addr_offset, bus.lut_in_bank0, i, lo_of(i + 1));
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.load_frame = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_full_load();
    test_bubbles();
    test_ignored_cmd();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
